// File: rtl/bcd_pkg.sv
// Shared BCD digit type and common-anode display polarity constants.
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam logic SEG_ON  = 1'b0;
   localparam logic SEG_OFF = 1'b1;
endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps up or down when enabled and flags carry/borrow
// combinationally when it is about to roll over.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc_en,
   input  logic dir,
   output bcd_t digit,
   output logic carry
);

   logic atTerminal;

   assign atTerminal = dir ? (digit == BCD_MAX) : (digit == '0);
   assign carry      = inc_en & atTerminal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (inc_en) begin
         if (dir)
            digit <= atTerminal ? bcd_t'(0) : bcd_t'(digit + 1'b1);
         else
            digit <= atTerminal ? BCD_MAX : bcd_t'(digit - 1'b1);
      end
   end

endmodule

// File: rtl/bcd_counter_scan.sv
// Cascaded BCD up/down counter with prescaler and a time-multiplexed
// digit scanner feeding a single shared 7-segment decoder.
module bcd_counter_scan
   import bcd_pkg::*;
#(
   parameter int NDIGITS  = 4,
   parameter int PRESCALE = 100_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clear,
   input  logic                     up_down,
   output logic [BCD_W*NDIGITS-1:0] count,
   output logic                     wrap,
   output logic [BCD_W-1:0]         BCD,
   output logic [NDIGITS-1:0]       anode
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIGITS > 1)  ? $clog2(NDIGITS)  : 1;

   localparam logic [PW-1:0]      PLAST     = PW'(PRESCALE - 1);
   localparam logic [SW-1:0]      SLAST     = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]      ILAST     = IW'(NDIGITS - 1);
   localparam logic [NDIGITS-1:0] ANODE_RST = ~NDIGITS'(1);

   logic [PW-1:0]      pcnt;
   logic [SW-1:0]      scnt;
   logic [IW-1:0]      idx;
   logic               tick;
   logic [NDIGITS:0]   carryChain;
   bcd_t               selDigit;
   logic [NDIGITS-1:0] anodeNext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pcnt <= '0;
      else if (clear)
         pcnt <= '0;
      else if (en)
         pcnt <= (pcnt == PLAST) ? '0 : PW'(pcnt + 1'b1);
   end

   assign tick          = en & ~clear & (pcnt == PLAST);
   assign carryChain[0] = tick;

   // Ripple chain: each decade steps only when every lower decade rolls over.
   for (genvar k = 0; k < NDIGITS; k++) begin : gDigit
      bcd_t digitVal;

      bcd_digit uDigit (
         .clk    (clk),
         .rst    (rst),
         .clear  (clear),
         .inc_en (carryChain[k]),
         .dir    (up_down),
         .digit  (digitVal),
         .carry  (carryChain[k+1])
      );

      assign count[BCD_W*k +: BCD_W] = digitVal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wrap <= 1'b0;
      else if (clear)
         wrap <= 1'b0;
      else
         wrap <= carryChain[NDIGITS];
   end

   // Scanner ignores en/clear so the display keeps refreshing while paused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt <= '0;
         idx  <= '0;
      end else if (scnt == SLAST) begin
         scnt <= '0;
         idx  <= (idx == ILAST) ? '0 : IW'(idx + 1'b1);
      end else begin
         scnt <= SW'(scnt + 1'b1);
      end
   end

   always_comb begin
      selDigit  = count[BCD_W*idx +: BCD_W];
      anodeNext = '1;
      for (int i = 0; i < NDIGITS; i++)
         anodeNext[i] = (idx == IW'(i)) ? SEG_ON : SEG_OFF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BCD   <= '0;
         anode <= ANODE_RST;
      end else begin
         BCD   <= selDigit;
         anode <= anodeNext;
      end
   end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them against two counter instances.
module tb_bcd_counter_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, clear, upDown;
   logic        enB, clearB, upDownB;
   logic [15:0] countA, countB;
   logic        wrapA, wrapB;
   logic [3:0]  bcdA, bcdB;
   logic [3:0]  anodeA, anodeB;

   int cyc    = 0;
   int relCyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] cnt;
      logic        w;
      logic [3:0]  bcd;
      logic [3:0]  an;
      string       name;
   } exp_t;

   exp_t q[$];

   int bcdSeq[8] = '{1, 1, 2, 2, 3, 3, 4, 4};
   int anSeq[8]  = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};

   bcd_counter_scan #(.NDIGITS(4), .PRESCALE(1), .SCAN_DIV(2)) dutA (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .up_down(upDown),
      .count(countA), .wrap(wrapA), .BCD(bcdA), .anode(anodeA)
   );

   bcd_counter_scan #(.NDIGITS(4), .PRESCALE(5), .SCAN_DIV(2)) dutB (
      .clk(clk), .rst(rst), .en(enB), .clear(clearB), .up_down(upDownB),
      .count(countB), .wrap(wrapB), .BCD(bcdB), .anode(anodeB)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] toBcd(int v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic push(int c, int k, int dec, bit w, int bcd, int an, string nm);
      exp_t e;
      e.cyc = c; e.kind = k; e.cnt = toBcd(dec); e.w = w;
      e.bcd = 4'(bcd); e.an = 4'(an); e.name = nm;
      q.push_back(e);
   endtask

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
         end else begin
            case (e.kind)
               0: begin
                  chk({e.name, ".countA"}, countA, e.cnt);
                  chk({e.name, ".wrapA"}, 16'(wrapA), 16'(e.w));
               end
               1: begin
                  chk({e.name, ".countB"}, countB, e.cnt);
                  chk({e.name, ".wrapB"}, 16'(wrapB), 16'(e.w));
               end
               2: begin
                  chk({e.name, ".bcdA"}, 16'(bcdA), 16'(e.bcd));
                  chk({e.name, ".anodeA"}, 16'(anodeA), 16'(e.an));
               end
               default: begin
                  chk({e.name, ".countA"}, countA, 16'h0000);
                  chk({e.name, ".wrapA"}, 16'(wrapA), 16'h0);
                  chk({e.name, ".bcdA"}, 16'(bcdA), 16'h0);
                  chk({e.name, ".anodeA"}, 16'(anodeA), 16'hE);
                  chk({e.name, ".countB"}, countB, 16'h0000);
                  chk({e.name, ".wrapB"}, 16'(wrapB), 16'h0);
                  chk({e.name, ".bcdB"}, 16'(bcdB), 16'h0);
                  chk({e.name, ".anodeB"}, 16'(anodeB), 16'hE);
               end
            endcase
         end
      end
   end

   initial begin
      int base;
      int ph;
      rst = 1'b1; en = 1'b0; clear = 1'b0; upDown = 1'b1;
      enB = 1'b0; clearB = 1'b0; upDownB = 1'b1;

      // Reset values, then idle with en low
      step(2);
      push(cyc, 3, 0, 0, 0, 0, "reset");
      step(1);
      rst = 1'b0;
      relCyc = cyc;
      for (int i = 0; i < 10; i++) begin
         push(cyc + 1, 0, 0, 0, 0, 0, "idle");
         step(1);
      end

      // Prescaler on the PRESCALE=5 instance: pause for 3 cycles, clear on a tick
      enB = 1'b1;
      base = cyc;
      push(base + 4, 1, 0, 0, 0, 0, "preHold");
      push(base + 5, 1, 1, 0, 0, 0, "preFirstTick");
      step(7);
      enB = 1'b0;
      step(3);
      enB = 1'b1;
      push(base + 12, 1, 1, 0, 0, 0, "preGapHold");
      push(base + 13, 1, 2, 0, 0, 0, "preGapTick");
      step(3);
      step(4);
      clearB = 1'b1;
      push(base + 18, 1, 0, 0, 0, 0, "clearOnTick");
      step(1);
      clearB = 1'b0;
      push(base + 22, 1, 0, 0, 0, 0, "postClearHold");
      push(base + 23, 1, 1, 0, 0, 0, "postClearTick");
      step(5);
      enB = 1'b0;

      // Up count through full wrap
      upDown = 1'b1;
      en = 1'b1;
      for (int j = 1; j <= 10000; j++) begin
         push(cyc + 1, 0, j % 10000, (j == 10000), 0, 0, "up");
         step(1);
      end

      // Down wrap then one more step
      upDown = 1'b0;
      push(cyc + 1, 0, 9999, 1, 0, 0, "downWrap");
      step(1);
      en = 1'b0;
      push(cyc + 1, 0, 9999, 0, 0, 0, "downHold");
      step(1);
      en = 1'b1;
      push(cyc + 1, 0, 9998, 0, 0, 0, "downStep");
      step(1);
      en = 1'b0;
      push(cyc + 1, 0, 9998, 0, 0, 0, "downIdle");
      step(1);

      // Load 4321 by clear + counting, then check the scan pattern
      clear = 1'b1;
      push(cyc + 1, 0, 0, 0, 0, 0, "clearA");
      step(1);
      clear = 1'b0;
      upDown = 1'b1;
      en = 1'b1;
      step(4321);
      en = 1'b0;
      push(cyc, 0, 4321, 0, 0, 0, "count4321");
      for (int j = 1; j <= 16; j++) begin
         ph = (cyc + j - relCyc - 1) % 8;
         push(cyc + j, 2, 0, 0, bcdSeq[ph], anSeq[ph], "scan4321");
      end
      step(16);

      // Async reset mid-cycle at 0573
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      en = 1'b1;
      step(573);
      en = 1'b0;
      push(cyc, 0, 573, 0, 0, 0, "count0573");
      step(1);
      @(posedge clk);
      #2 rst = 1'b1;
      push(cyc, 3, 0, 0, 0, 0, "asyncReset");
      @(posedge clk);
      #1 rst = 1'b0;
      relCyc = cyc;
      for (int j = 1; j <= 8; j++) begin
         ph = (j - 1) % 8;
         push(cyc + j, 2, 0, 0, 0, anSeq[ph], "scanRestart");
      end
      push(cyc + 8, 0, 0, 0, 0, 0, "postReset");
      step(9);

      step(3);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
